data_mem_responder: RTL

- Memory-side responder for the load/store request interface driven by the control unit (E, RW, SIZE, SE), plus address and store data from the datapath.
- Holds a byte-addressed, big-endian data RAM.
- Accepts one request at a time and inserts a programmable wait latency.
- Returns zero- or sign-extended load data, or commits byte/halfword/word stores, with a one-cycle response strobe.

---
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - big-endian data RAM responder with programmable wait latency
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid, E, RW, SIZE, SE  request strobe, enable, load/store, size, sign-extend
//   addr, wdata                 byte address (low ADDR_W bits used), store data
//   req_ready                   idle and able to accept a request
//   rsp_valid                   one-cycle response strobe
//   rdata, err                  load result / misaligned-or-illegal flag, valid with rsp_valid
module data_mem_responder #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        E,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic        SE,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, se_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [7:0] mem [0:(2**ADDR_W)-1];

    logic              accept;
    logic              enter_resp;
    logic              op_rw, op_se;
    logic [1:0]        op_size;
    logic [ADDR_W-1:0] op_a0, op_a1, op_a2, op_a3;
    logic [31:0]       op_wdata;
    logic              op_err;
    logic [7:0]        rd_b0, rd_b1, rd_b2, rd_b3;
    logic [31:0]       ld_val;

    // Upper address bits are deliberately dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W];

    assign accept    = req_valid && E && (state_q == IDLE);
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rdata     = rdata_q;
    assign err       = err_q;

    // With zero latency the RAM access happens on the accept edge itself, so
    // the live request inputs are used instead of the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            op_rw    = RW;
            op_se    = SE;
            op_size  = SIZE;
            op_a0    = addr[ADDR_W-1:0];
            op_wdata = wdata;
        end else begin
            op_rw    = rw_q;
            op_se    = se_q;
            op_size  = size_q;
            op_a0    = addr_q;
            op_wdata = wdata_q;
        end
    end

    assign op_a1 = op_a0 + ADDR_W'(1);
    assign op_a2 = op_a0 + ADDR_W'(2);
    assign op_a3 = op_a0 + ADDR_W'(3);

    assign op_err = (op_size == 2'b11) ||
                    ((op_size == 2'b01) && op_a0[0]) ||
                    ((op_size == 2'b10) && (op_a0[1:0] != 2'b00));

    assign rd_b0 = mem[op_a0];
    assign rd_b1 = mem[op_a1];
    assign rd_b2 = mem[op_a2];
    assign rd_b3 = mem[op_a3];

    always_comb begin
        ld_val = 32'd0;
        case (op_size)
            2'b00:   ld_val = op_se ? {{24{rd_b0[7]}}, rd_b0} : {24'd0, rd_b0};
            2'b01:   ld_val = op_se ? {{16{rd_b0[7]}}, rd_b0, rd_b1} : {16'd0, rd_b0, rd_b1};
            2'b10:   ld_val = {rd_b0, rd_b1, rd_b2, rd_b3};
            default: ld_val = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 4'd0;
                    if (LATENCY == 0) state_d = RESP;
                    else              state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rw_q    <= RW;
                se_q    <= SE;
                size_q  <= SIZE;
                addr_q  <= addr[ADDR_W-1:0];
                wdata_q <= wdata;
            end
            // Response registers are only non-zero for the single RESP cycle.
            rdata_q <= (enter_resp && !op_rw && !op_err) ? ld_val : 32'd0;
            err_q   <= enter_resp && op_err;
        end
    end

    // RAM has no reset; rst_n gating keeps a request seen during reset from committing.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && op_rw && !op_err) begin
            case (op_size)
                2'b00: mem[op_a0] <= op_wdata[7:0];
                2'b01: begin
                    mem[op_a0] <= op_wdata[15:8];
                    mem[op_a1] <= op_wdata[7:0];
                end
                2'b10: begin
                    mem[op_a0] <= op_wdata[31:24];
                    mem[op_a1] <= op_wdata[23:16];
                    mem[op_a2] <= op_wdata[15:8];
                    mem[op_a3] <= op_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule
